// File: rtl/analytic_pair_aligner.sv
// Purpose : pairs the in-phase (delay line) and quadrature (Hilbert FIR) sample streams into aligned (I,Q) words.
// Latency : 2 cycles input-to-output (push edge, then pop into the output register); 1 pair/cycle sustained.
// Backpress: inputs cannot be stalled; full lanes drop and flag ovf_*; output held stable while m_valid && !m_ready.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   i_din/i_valid         in-phase sample lane, no backpressure
//   q_din/q_valid         quadrature sample lane, no backpressure
//   flush                 synchronous clear of FIFOs, output register, flags and pair counter
//   m_i/m_q/m_valid       registered aligned pair, accepted on m_valid && m_ready
//   m_ready               downstream accept
//   ovf_i/ovf_q           sticky: a sample was dropped because its lane FIFO was full
//   desync                sticky: lane skew exceeded SKEW_MAX and both lanes were resynchronised
//   pair_count            wrapping count of accepted pairs
module analytic_pair_aligner #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int SKEW_MAX   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] q_din,
  input  logic              q_valid,
  input  logic              flush,
  output logic [DATA_W-1:0] m_i,
  output logic [DATA_W-1:0] m_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              ovf_i,
  output logic              ovf_q,
  output logic              desync,
  output logic [15:0]       pair_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] SKEW_LIM = CW'(SKEW_MAX);

  typedef enum logic {RUN, RESYNC} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem_i [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_i, rd_i, wr_q, rd_q;
  logic [CW-1:0]     cnt_i, cnt_q, cnt_i_nxt, cnt_q_nxt, skew;
  logic              run, clr, out_free, pop;
  logic              push_i, push_q, drop_i, drop_q;

  // Lanes only move in RUN; flush and the RESYNC cycle both discard everything.
  assign run      = (state == RUN) && !flush;
  assign clr      = flush || (state == RESYNC);
  assign out_free = !m_valid || m_ready;

  // Pairs leave only together, so the lanes never drift through popping.
  assign pop = run && (cnt_i != '0) && (cnt_q != '0) && out_free;

  // A full lane still accepts when the same edge frees a slot.
  assign push_i = run && i_valid && ((cnt_i != FULL_CNT) || pop);
  assign push_q = run && q_valid && ((cnt_q != FULL_CNT) || pop);
  assign drop_i = run && i_valid && (cnt_i == FULL_CNT) && !pop;
  assign drop_q = run && q_valid && (cnt_q == FULL_CNT) && !pop;

  // Skew is judged on the occupancies this edge will leave behind.
  assign cnt_i_nxt = clr ? '0 : cnt_i + CW'(push_i) - CW'(pop);
  assign cnt_q_nxt = clr ? '0 : cnt_q + CW'(push_q) - CW'(pop);
  assign skew      = (cnt_i_nxt >= cnt_q_nxt) ? (cnt_i_nxt - cnt_q_nxt)
                                              : (cnt_q_nxt - cnt_i_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // RESYNC lasts exactly one cycle, so RUN is the fall-through.
  always_comb begin
    state_nxt = RUN;
    if (!flush && (state == RUN) && (skew > SKEW_LIM)) begin
      state_nxt = RESYNC;
    end
  end

  // Sample storage carries no reset; validity lives in the pointers and counts.
  always_ff @(posedge clk) begin
    if (push_i) mem_i[wr_i] <= i_din;
    if (push_q) mem_q[wr_q] <= q_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_i  <= '0;
      rd_i  <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_i <= '0;
      cnt_q <= '0;
    end else begin
      cnt_i <= cnt_i_nxt;
      cnt_q <= cnt_q_nxt;
      if (clr) begin
        wr_i <= '0;
        rd_i <= '0;
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push_i) wr_i <= wr_i + AW'(1);
        if (push_q) wr_q <= wr_q + AW'(1);
        if (pop) begin
          rd_i <= rd_i + AW'(1);
          rd_q <= rd_q + AW'(1);
        end
      end
    end
  end

  // Output register; RESYNC leaves a pending pair in place so it is still delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_i        <= '0;
      m_q        <= '0;
      m_valid    <= 1'b0;
      ovf_i      <= 1'b0;
      ovf_q      <= 1'b0;
      desync     <= 1'b0;
      pair_count <= '0;
    end else if (flush) begin
      m_i        <= '0;
      m_q        <= '0;
      m_valid    <= 1'b0;
      ovf_i      <= 1'b0;
      ovf_q      <= 1'b0;
      desync     <= 1'b0;
      pair_count <= '0;
    end else begin
      if (pop) begin
        m_i     <= mem_i[rd_i];
        m_q     <= mem_q[rd_q];
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (m_valid && m_ready) pair_count <= pair_count + 16'd1;
      if (drop_i) ovf_i <= 1'b1;
      if (drop_q) ovf_q <= 1'b1;
      if (state_nxt == RESYNC) desync <= 1'b1;
    end
  end

endmodule

// File: tb/tb_analytic_pair_aligner.sv
module tb_analytic_pair_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_din, q_din;
  logic        i_valid, q_valid, flush;
  logic [15:0] m_i, m_q;
  logic        m_valid, m_ready;
  logic        ovf_i, ovf_q, desync;
  logic [15:0] pair_count;

  int n_pass = 0;
  int n_tot  = 0;
  logic [15:0] got_i [$];
  logic [15:0] got_q [$];

  analytic_pair_aligner #(.DATA_W(16), .FIFO_DEPTH(8), .SKEW_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_din(i_din), .i_valid(i_valid),
    .q_din(q_din), .q_valid(q_valid),
    .flush(flush),
    .m_i(m_i), .m_q(m_q), .m_valid(m_valid), .m_ready(m_ready),
    .ovf_i(ovf_i), .ovf_q(ovf_q), .desync(desync),
    .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  // Advance one edge; record the pair the downstream accepted on that edge.
  task automatic tick();
    logic acc;
    logic [15:0] ci, cq;
    acc = m_valid && m_ready && !flush && rst_n;
    ci  = m_i;
    cq  = m_q;
    @(posedge clk);
    #1;
    if (acc) begin
      got_i.push_back(ci);
      got_q.push_back(cq);
    end
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0;
    q_valid = 1'b0;
    i_din   = '0;
    q_din   = '0;
  endtask

  task automatic drive_pair(input int n);
    i_din   = 16'(n);
    q_din   = 16'(-n);
    i_valid = 1'b1;
    q_valid = 1'b1;
  endtask

  task automatic do_flush();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    got_i.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
    idle_inputs();
    #1;
    n_tot++;
    if (m_valid !== 1'b0 || m_i !== 16'd0 || m_q !== 16'd0) $display("FAIL reset_out: m_valid=%b m_i=%h m_q=%h want 0 0 0", m_valid, m_i, m_q);
    else n_pass++;
    #21;
    n_tot++;
    if (ovf_i !== 1'b0 || ovf_q !== 1'b0 || desync !== 1'b0 || pair_count !== 16'd0)
      $display("FAIL reset_flags: ovf_i=%b ovf_q=%b desync=%b count=%0d want 0 0 0 0", ovf_i, ovf_q, desync, pair_count);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lockstep();
    m_ready = 1'b1;
    got_i.delete(); got_q.delete();
    for (int n = 1; n <= 20; n++) begin
      drive_pair(n);
      tick();
      n_tot++;
      if (n == 1) begin
        if (m_valid !== 1'b0) $display("FAIL lock_latency: m_valid=%b want 0 one edge after first push", m_valid);
        else n_pass++;
      end else begin
        if (m_valid !== 1'b1 || m_i !== 16'(n-1) || m_q !== 16'(-(n-1)))
          $display("FAIL lock_out%0d: v=%b i=%h q=%h want 1 %h %h", n, m_valid, m_i, m_q, 16'(n-1), 16'(-(n-1)));
        else n_pass++;
      end
    end
    idle_inputs();
    repeat (3) tick();
    n_tot++;
    if (got_i.size() != 20) $display("FAIL lock_npairs: got %0d want 20", got_i.size());
    else n_pass++;
    for (int k = 0; k < 20 && k < got_i.size(); k++) begin
      n_tot++;
      if (got_i[k] !== 16'(k+1) || got_q[k] !== 16'(-(k+1)))
        $display("FAIL lock_pair%0d: got (%h,%h) want (%h,%h)", k, got_i[k], got_q[k], 16'(k+1), 16'(-(k+1)));
      else n_pass++;
    end
    n_tot++;
    if (pair_count !== 16'd20 || ovf_i !== 1'b0 || ovf_q !== 1'b0 || desync !== 1'b0)
      $display("FAIL lock_status: count=%0d ovf_i=%b ovf_q=%b desync=%b want 20 0 0 0", pair_count, ovf_i, ovf_q, desync);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int exp_v [$];
    do_flush();
    for (int t = 1; t <= 30; t++) begin
      drive_pair(t);
      m_ready = (t >= 3 && t <= 12) ? 1'b0 : 1'b1;
      tick();
      if (t >= 3 && t <= 12) begin
        n_tot++;
        if (m_valid !== 1'b1 || m_i !== 16'd1 || m_q !== 16'hFFFF)
          $display("FAIL bp_hold%0d: v=%b i=%h q=%h want 1 0001 ffff", t, m_valid, m_i, m_q);
        else n_pass++;
      end
      if (t == 9) begin
        n_tot++;
        if (ovf_i !== 1'b0 || ovf_q !== 1'b0) $display("FAIL bp_noovf_full: ovf_i=%b ovf_q=%b want 0 0", ovf_i, ovf_q);
        else n_pass++;
      end
      if (t == 12) begin
        n_tot++;
        if (ovf_i !== 1'b1 || ovf_q !== 1'b1) $display("FAIL bp_ovf: ovf_i=%b ovf_q=%b want 1 1", ovf_i, ovf_q);
        else n_pass++;
      end
    end
    idle_inputs();
    m_ready = 1'b1;
    repeat (10) tick();
    for (int v = 1; v <= 9; v++) exp_v.push_back(v);
    for (int v = 13; v <= 30; v++) exp_v.push_back(v);
    n_tot++;
    if (got_i.size() != exp_v.size()) $display("FAIL bp_npairs: got %0d want %0d", got_i.size(), exp_v.size());
    else n_pass++;
    for (int k = 0; k < exp_v.size() && k < got_i.size(); k++) begin
      n_tot++;
      if (got_i[k] !== 16'(exp_v[k]) || got_q[k] !== 16'(-exp_v[k]))
        $display("FAIL bp_pair%0d: got (%h,%h) want (%h,%h)", k, got_i[k], got_q[k], 16'(exp_v[k]), 16'(-exp_v[k]));
      else n_pass++;
    end
    n_tot++;
    if (pair_count !== 16'd27 || m_valid !== 1'b0) $display("FAIL bp_end: count=%0d v=%b want 27 0", pair_count, m_valid);
    else n_pass++;
  endtask

  task automatic test_skew();
    do_flush();
    m_ready = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      idle_inputs();
      i_din = 16'(n); i_valid = 1'b1;
      tick();
      if (n == 4) begin
        n_tot++;
        if (desync !== 1'b0) $display("FAIL skew_at_limit: desync=%b want 0", desync);
        else n_pass++;
      end
    end
    n_tot++;
    if (desync !== 1'b1) $display("FAIL skew_desync: desync=%b want 1", desync);
    else n_pass++;
    drive_pair(6);
    tick();
    drive_pair(7);
    tick();
    n_tot++;
    if (m_valid !== 1'b0) $display("FAIL skew_empty: m_valid=%b want 0", m_valid);
    else n_pass++;
    idle_inputs();
    tick();
    n_tot++;
    if (m_valid !== 1'b1 || m_i !== 16'd7 || m_q !== 16'(-7))
      $display("FAIL skew_pair7: v=%b i=%h q=%h want 1 0007 fff9", m_valid, m_i, m_q);
    else n_pass++;
    n_tot++;
    if (desync !== 1'b1 || ovf_i !== 1'b0 || ovf_q !== 1'b0)
      $display("FAIL skew_flags: desync=%b ovf_i=%b ovf_q=%b want 1 0 0", desync, ovf_i, ovf_q);
    else n_pass++;
    tick();
  endtask

  task automatic test_full_pop();
    do_flush();
    m_ready = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      drive_pair(n);
      tick();
    end
    n_tot++;
    if (ovf_i !== 1'b0 || ovf_q !== 1'b0 || m_i !== 16'd1) $display("FAIL full_setup: ovf_i=%b ovf_q=%b i=%h want 0 0 0001", ovf_i, ovf_q, m_i);
    else n_pass++;
    m_ready = 1'b1;
    drive_pair(10);
    tick();
    n_tot++;
    if (ovf_i !== 1'b0 || ovf_q !== 1'b0 || m_i !== 16'd2)
      $display("FAIL full_pop: ovf_i=%b ovf_q=%b i=%h want 0 0 0002", ovf_i, ovf_q, m_i);
    else n_pass++;
    idle_inputs();
    repeat (12) tick();
    n_tot++;
    if (got_i.size() != 10) $display("FAIL full_npairs: got %0d want 10", got_i.size());
    else n_pass++;
    for (int k = 0; k < 10 && k < got_i.size(); k++) begin
      n_tot++;
      if (got_i[k] !== 16'(k+1) || got_q[k] !== 16'(-(k+1)))
        $display("FAIL full_pair%0d: got (%h,%h) want (%h,%h)", k, got_i[k], got_q[k], 16'(k+1), 16'(-(k+1)));
      else n_pass++;
    end
    n_tot++;
    if (pair_count !== 16'd10) $display("FAIL full_count: count=%0d want 10", pair_count);
    else n_pass++;
  endtask

  task automatic test_flush();
    do_flush();
    m_ready = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      idle_inputs();
      i_din = 16'(n); i_valid = 1'b1;
      tick();
    end
    idle_inputs();
    tick();
    for (int t = 1; t <= 14; t++) begin
      drive_pair(t);
      m_ready = (t <= 3) ? 1'b1 : 1'b0;
      tick();
    end
    n_tot++;
    if (pair_count !== 16'd1 || m_valid !== 1'b1 || m_i !== 16'd2 || ovf_i !== 1'b1 || ovf_q !== 1'b1 || desync !== 1'b1)
      $display("FAIL flush_setup: count=%0d v=%b i=%h ovf=%b%b desync=%b want 1 1 0002 11 1", pair_count, m_valid, m_i, ovf_i, ovf_q, desync);
    else n_pass++;
    drive_pair(15);
    m_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tot++;
    if (m_valid !== 1'b0 || pair_count !== 16'd0) $display("FAIL flush_out: v=%b count=%0d want 0 0", m_valid, pair_count);
    else n_pass++;
    n_tot++;
    if (ovf_i !== 1'b0 || ovf_q !== 1'b0 || desync !== 1'b0)
      $display("FAIL flush_flags: ovf_i=%b ovf_q=%b desync=%b want 0 0 0", ovf_i, ovf_q, desync);
    else n_pass++;
    idle_inputs();
    m_ready = 1'b1;
    repeat (2) tick();
    n_tot++;
    if (m_valid !== 1'b0 || pair_count !== 16'd0) $display("FAIL flush_empty: v=%b count=%0d want 0 0", m_valid, pair_count);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_flush();
    m_ready = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      drive_pair(n);
      tick();
    end
    n_tot++;
    if (pair_count !== 16'd3 || m_valid !== 1'b1) $display("FAIL arst_setup: count=%0d v=%b want 3 1", pair_count, m_valid);
    else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_tot++;
    if (m_valid !== 1'b0 || m_i !== 16'd0 || m_q !== 16'd0 || pair_count !== 16'd0)
      $display("FAIL arst_immediate: v=%b i=%h q=%h count=%0d want 0 0 0 0", m_valid, m_i, m_q, pair_count);
    else n_pass++;
    #2;
    rst_n = 1'b1;
    drive_pair(100);
    tick();
    n_tot++;
    if (m_valid !== 1'b0) $display("FAIL arst_first: v=%b want 0", m_valid);
    else n_pass++;
    idle_inputs();
    tick();
    n_tot++;
    if (m_valid !== 1'b1 || m_i !== 16'd100 || m_q !== 16'(-100))
      $display("FAIL arst_pair: v=%b i=%h q=%h want 1 0064 ff9c", m_valid, m_i, m_q);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lockstep();
    test_backpressure();
    test_skew();
    test_full_pop();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
